// File: rtl/soc_button_pkg.sv
// Shared types and constants for the button poller: Avalon FSM states,
// PIO register offset and bus data width.
package soc_button_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2
    } state_e;

    localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;
    localparam int         AVM_DATA_W      = 32;

endpackage

// File: rtl/soc_button_debounce.sv
// Debouncer: the level toggles only after DEBOUNCE_CNT consecutive samples that
// differ from it; the toggle produces a registered one-cycle press or release pulse.
module soc_button_debounce #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic sample_valid,
    input  logic sample,
    output logic level,
    output logic press,
    output logic release_pulse   // "release" is a reserved word in SystemVerilog
);

    localparam int              CW       = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW:0]     CNT_LAST = (CW + 1)'(DEBOUNCE_CNT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic [CW:0]   cnt_inc;

    // One bit wider than the counter so the compare never wraps.
    assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sample_valid) begin
            if (sample == level_q) begin
                cnt_d = '0;
            end else if (cnt_inc == CNT_LAST) begin
                cnt_d   = '0;
                level_d = ~level_q;
                press_d = ~level_q;
                rel_d   = level_q;
            end else begin
                cnt_d = cnt_inc[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/soc_button_poller.sv
// Avalon-MM read initiator that polls the button PIO data register and debounces bit 0.
// Optional sticky press interrupt (irq/irq_ack) enabled by SOC_BUTTON_POLLER_IRQ_EN.
module soc_button_poller
    import soc_button_pkg::*;
#(
    parameter int POLL_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    output logic                  btn_level,
    output logic                  btn_press,
    output logic                  btn_release,
`ifdef SOC_BUTTON_POLLER_IRQ_EN
    output logic                  irq,
    input  logic                  irq_ack,
`endif
    output logic                  poll_overrun
);

    localparam int             TW           = $clog2(POLL_DIV);
    localparam logic [TW-1:0]  TIMER_RELOAD = TW'(POLL_DIV - 1);
    localparam logic [1:0]     LAT_RELOAD   = 2'(READ_LATENCY - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    lat_q, lat_d;
    logic          read_q, read_d;
    logic          overrun_q, overrun_d;
    logic          tick;
    logic          sample_valid;
    logic          unused_readdata;

    assign tick         = (timer_q == '0);
    assign sample_valid = (state_q == LAT) && (lat_q == '0);

    always_comb begin
        timer_d   = tick ? TIMER_RELOAD : timer_q - TW'(1);
        state_d   = state_q;
        lat_d     = lat_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: if (tick) state_d = REQ;
            REQ: begin
                if (!avm_waitrequest) begin
                    state_d = LAT;
                    lat_d   = LAT_RELOAD;
                end
            end
            LAT: begin
                if (lat_q == '0) state_d = IDLE;
                else             lat_d   = lat_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
        // A tick while busy is dropped rather than queued.
        if (tick && (state_q != IDLE)) overrun_d = 1'b1;
        read_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= TIMER_RELOAD;
            lat_q     <= '0;
            read_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lat_q     <= lat_d;
            read_q    <= read_d;
            overrun_q <= overrun_d;
        end
    end

    soc_button_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clk           (clk),
        .srst          (reset),
        .sample_valid  (sample_valid),
        .sample        (avm_readdata[0]),
        .level         (btn_level),
        .press         (btn_press),
        .release_pulse (btn_release)
    );

`ifdef SOC_BUTTON_POLLER_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_ack)   irq_d = 1'b0;
        if (btn_press) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    assign avm_address     = PIO_DATA_OFFSET;
    assign avm_read        = read_q;
    assign poll_overrun    = overrun_q;
    assign unused_readdata = ^avm_readdata[AVM_DATA_W-1:1];

endmodule
